// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    // Stored destination width; wide enough for any supported register address width.
    localparam int unsigned RD_W = 8;

    localparam int unsigned FWD_RF = 0;

    // addi x0, x0, 0 -- the instruction loaded into IF/ID or ID/EX on flush/bubble
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wen;
        logic            load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-source forwarding select: youngest matching writer, readiness check and operand mux.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned SRC_W      = 2
) (
    input  logic                  src_used_i,
    input  logic [AW-1:0]         src_addr_i,
    input  logic [XLEN-1:0]       rf_data_i,
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  logic [DEPTH*XLEN-1:0] stg_data_i,
    output logic [XLEN-1:0]       fwd_data_o,
    output logic [SRC_W-1:0]      fwd_src_o,
    output logic                  not_ready_o
);

    logic [DEPTH-1:0] match;
    logic             hit;
    logic             hit_ready;
    logic [XLEN-1:0]  hit_data;
    logic [SRC_W-1:0] hit_src;

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            match[k] = src_used_i && (src_addr_i != '0) && sb_i[k].valid && sb_i[k].wen &&
                       (sb_i[k].rd == RD_W'(src_addr_i));
        end
    end

    // Lowest index is the youngest writer; once found, older matches are ignored.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        hit_src   = SRC_W'(FWD_RF);
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (match[k] && !hit) begin
                hit       = 1'b1;
                hit_ready = !sb_i[k].load || (k >= int'(LOAD_STAGE));
                hit_data  = stg_data_i[k*XLEN +: XLEN];
                hit_src   = SRC_W'(k + 1);
            end
        end
    end

    always_comb begin
        fwd_data_o  = rf_data_i;
        fwd_src_o   = SRC_W'(FWD_RF);
        not_ready_o = hit && !hit_ready;
        if (hit && hit_ready) begin
            fwd_data_o = hit_data;
            fwd_src_o  = hit_src;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and flush controller beside the ID stage: in-flight writer scoreboard,
// operand forwarding, load-use stall, redirect flush and saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rs1_addr,
    input  logic [AW-1:0]                id_rs2_addr,
    input  logic                         id_rs1_used,
    input  logic                         id_rs2_used,
    input  logic [AW-1:0]                id_rd_addr,
    input  logic                         id_rf_wen,
    input  logic                         id_is_load,
    input  logic [XLEN-1:0]              id_rs1_data,
    input  logic [XLEN-1:0]              id_rs2_data,
    input  logic [DEPTH*XLEN-1:0]        stg_data,
    input  logic                         ex_redirect,
    output logic [XLEN-1:0]              fwd_rs1_data,
    output logic [XLEN-1:0]              fwd_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rs1_src,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rs2_src,
    output logic                         stall,
    output logic                         flush_if_id,
    output logic                         bubble_ex,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int unsigned SRC_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  rs1_not_ready, rs2_not_ready;

    hazard_fwd_sel #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SRC_W(SRC_W)
    ) u_fwd_rs1 (
        .src_used_i  (id_rs1_used),
        .src_addr_i  (id_rs1_addr),
        .rf_data_i   (id_rs1_data),
        .sb_i        (sb_q),
        .stg_data_i  (stg_data),
        .fwd_data_o  (fwd_rs1_data),
        .fwd_src_o   (fwd_rs1_src),
        .not_ready_o (rs1_not_ready)
    );

    hazard_fwd_sel #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SRC_W(SRC_W)
    ) u_fwd_rs2 (
        .src_used_i  (id_rs2_used),
        .src_addr_i  (id_rs2_addr),
        .rf_data_i   (id_rs2_data),
        .sb_i        (sb_q),
        .stg_data_i  (stg_data),
        .fwd_data_o  (fwd_rs2_data),
        .fwd_src_o   (fwd_rs2_src),
        .not_ready_o (rs2_not_ready)
    );

    // A redirect squashes the ID instruction, so it overrides any load-use stall.
    always_comb begin
        stall       = id_valid && (rs1_not_ready || rs2_not_ready) && !ex_redirect;
        flush_if_id = ex_redirect;
        bubble_ex   = stall || ex_redirect;
    end

    always_comb begin
        sb_d          = sb_q;
        sb_d[0].valid = id_valid && !stall && !ex_redirect;
        sb_d[0].rd    = RD_W'(id_rd_addr);
        sb_d[0].wen   = id_rf_wen;
        sb_d[0].load  = id_is_load;
        for (int k = 1; k < int'(DEPTH); k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a LOAD_STAGE=1 instance and a LOAD_STAGE=2, CNT_W=2 instance.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_rf_wen, id_is_load;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [31:0] stg [3];
    logic [95:0] stg_data;
    logic        ex_redirect;

    logic [31:0] a_d1, a_d2, b_d1, b_d2;
    logic [1:0]  a_s1, a_s2, b_s1, b_s2;
    logic        a_st, a_fl, a_bb, b_st, b_fl, b_bb;
    logic [15:0] a_sc, a_fc;
    logic [1:0]  b_sc, b_fc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        bit          sel;
        logic        st, fl, bb;
        logic [1:0]  s1, s2;
        logic [31:0] d1, d2;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;
    assign stg_data = {stg[2], stg[1], stg[0]};

    hazard_ctrl #(.LOAD_STAGE(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stg_data(stg_data), .ex_redirect(ex_redirect),
        .fwd_rs1_data(a_d1), .fwd_rs2_data(a_d2),
        .fwd_rs1_src(a_s1), .fwd_rs2_src(a_s2),
        .stall(a_st), .flush_if_id(a_fl), .bubble_ex(a_bb),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_ctrl #(.LOAD_STAGE(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stg_data(stg_data), .ex_redirect(ex_redirect),
        .fwd_rs1_data(b_d1), .fwd_rs2_data(b_d2),
        .fwd_rs1_src(b_s1), .fwd_rs2_src(b_s2),
        .stall(b_st), .flush_if_id(b_fl), .bubble_ex(b_bb),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    function automatic logic [31:0] model_data(logic [1:0] src, logic [31:0] rf);
        if (src == 2'd0) return rf;
        return stg[int'(src) - 1];
    endfunction

    task automatic check(string nm, string fld, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, expv);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued expectation is checked.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                check(e.nm, "stall",  32'(a_st), 32'(e.st));
                check(e.nm, "flush",  32'(a_fl), 32'(e.fl));
                check(e.nm, "bubble", 32'(a_bb), 32'(e.bb));
                check(e.nm, "src1",   32'(a_s1), 32'(e.s1));
                check(e.nm, "data1",  a_d1,      e.d1);
                check(e.nm, "src2",   32'(a_s2), 32'(e.s2));
                check(e.nm, "data2",  a_d2,      e.d2);
                check(e.nm, "scnt",   32'(a_sc), 32'(e.sc));
                check(e.nm, "fcnt",   32'(a_fc), 32'(e.fc));
            end else begin
                check(e.nm, "stall",  32'(b_st), 32'(e.st));
                check(e.nm, "flush",  32'(b_fl), 32'(e.fl));
                check(e.nm, "bubble", 32'(b_bb), 32'(e.bb));
                check(e.nm, "src1",   32'(b_s1), 32'(e.s1));
                check(e.nm, "data1",  b_d1,      e.d1);
                check(e.nm, "src2",   32'(b_s2), 32'(e.s2));
                check(e.nm, "data2",  b_d2,      e.d2);
                check(e.nm, "scnt",   32'(b_sc), 32'(e.sc));
                check(e.nm, "fcnt",   32'(b_fc), 32'(e.fc));
            end
        end
    end

    task automatic step(string nm, bit sel, logic v,
                        logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                        logic [4:0] rd, logic wen, logic ld, logic redir, logic rst,
                        logic e_st, logic [1:0] e_s1, logic [1:0] e_s2,
                        logic [15:0] e_sc, logic [15:0] e_fc);
        exp_t e;
        id_valid    = v;
        id_rs1_addr = r1;
        id_rs1_used = u1;
        id_rs2_addr = r2;
        id_rs2_used = u2;
        id_rd_addr  = rd;
        id_rf_wen   = wen;
        id_is_load  = ld;
        ex_redirect = redir;
        reset       = rst;
        e.nm  = nm;
        e.sel = sel;
        e.st  = e_st;
        e.fl  = redir;
        e.bb  = e_st | redir;
        e.s1  = e_s1;
        e.s2  = e_s2;
        e.d1  = model_data(e_s1, id_rs1_data);
        e.d2  = model_data(e_s2, id_rs2_data);
        e.sc  = e_sc;
        e.fc  = e_fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rf_wen = 1'b0; id_is_load = 1'b0;
        ex_redirect = 1'b0;
        id_rs1_data = 32'h0000_0100;
        id_rs2_data = 32'h0000_0200;
        stg[0] = 32'h11; stg[1] = 32'h22; stg[2] = 32'h33;
        repeat (2) @(posedge clk);
        #1;

        //   name            sel v  r1 u1 r2 u2 rd wen ld rdr rst st s1 s2 scnt fcnt
        step("reset_state",  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("add_x5",       0, 1,  0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("b2b_fwd",      0, 1,  5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("lw_x6",        0, 1,  0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("lu_stall",     0, 1,  6, 1, 5, 1, 8, 1, 0, 0, 0, 1, 0, 3, 0, 0);
        step("lu_fwd",       0, 1,  6, 1, 5, 1, 8, 1, 0, 0, 0, 0, 2, 0, 1, 0);
        step("fwd_x8",       0, 1,  8, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        step("x0_read",      0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("lw_x9",        0, 1,  0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        step("rs2_unused",   0, 1,  0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("add_x7a",      0, 1,  0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("nowrite_x7",   0, 1,  0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("add_x7b",      0, 1,  0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        stg[0] = 32'hA; stg[2] = 32'hB;
        step("youngest",     0, 1,  7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("lw_x7",        0, 1,  0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        step("young_stall",  0, 1,  7, 1, 0, 0,10, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        step("ld_fwd_e1",    0, 1,  7, 1, 0, 0,10, 1, 0, 0, 0, 0, 2, 0, 2, 0);
        step("lw_x11",       0, 1,  0, 0, 0, 0,11, 1, 1, 0, 0, 0, 0, 0, 2, 0);
        step("redir_stall",  0, 1, 11, 1, 0, 0,10, 1, 0, 1, 0, 0, 0, 0, 2, 0);
        step("post_redir",   0, 1, 10, 1,11, 1, 0, 0, 0, 0, 0, 0, 3, 2, 2, 1);
        step("lw_x12",       0, 1,  0, 0, 0, 0,12, 1, 1, 0, 0, 0, 0, 0, 2, 1);
        step("stall_reset",  0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 1);
        step("after_reset",  0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step("d2_lw_x6",     1, 1,  0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("d2_stall1",    1, 1,  6, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step("d2_stall2",    1, 1,  6, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        step("d2_fwd",       1, 1,  6, 1, 0, 0, 8, 1, 0, 0, 0, 0, 3, 0, 2, 0);
        step("d2_lw_x13",    1, 1,  0, 0, 0, 0,13, 1, 1, 0, 0, 0, 0, 0, 2, 0);
        step("d2_stall3",    1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
        step("d2_stall4",    1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        step("d2_fwd2",      1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);
        step("d2_lw_x14",    1, 1,  0, 0, 0, 0,14, 1, 1, 0, 0, 0, 0, 0, 3, 0);
        step("d2_stall5",    1, 1,  0, 0,14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        step("d2_stall6",    1, 1,  0, 0,14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        step("d2_fwd3",      1, 1,  0, 0,14, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);

        id_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
